ha_fault_monitor: RTL and testbench

HA_FAULT_MONITOR -- requirements
Module: ha_fault_monitor

---
 rtl/ha_fault_monitor.sv | 198 +++++++++++++++++++
 tb/tb_ha_fault_monitor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ha_fault_monitor.sv
// ha_fault_monitor: drives the four half-adder input vectors into an external DUT,
// counts output mismatches and (with HA_STUCK_DIAG_EN defined) diagnoses stuck-at outputs.
`default_nettype none

module ha_fault_monitor #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned ROUNDS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       dut_sum_i,
    input  logic       dut_carry_i,
    output logic       a_o,
    output logic       b_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [7:0] err_count_o,
    output logic [3:0] fault_flags_o,
    output logic [1:0] first_fail_o,
    output logic       sum_stuck0_o,
    output logic       sum_stuck1_o,
    output logic       carry_stuck0_o,
    output logic       carry_stuck1_o
);

    localparam logic [3:0] C_SETTLE = 4'(SETTLE);
    localparam logic [7:0] C_ROUNDS = 8'(ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] round_q, round_d;
    logic [7:0] err_q, err_d;
    logic [3:0] flags_q, flags_d;
    logic [1:0] ff_q, ff_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;

    logic w_accept;
    logic w_mismatch;
    logic w_finish;

    assign w_accept   = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;
    assign w_mismatch = (dut_sum_i != (vec_q[1] ^ vec_q[0])) || (dut_carry_i != (vec_q[1] & vec_q[0]));
    assign w_finish   = (state_q == S_CHECK) && (vec_q == 2'd3) && ((round_q + 8'd1) == C_ROUNDS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= 2'd0;
            cnt_q   <= 4'd0;
            round_q <= 8'd0;
            err_q   <= 8'd0;
            flags_q <= 4'd0;
            ff_q    <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
            err_q   <= err_d;
            flags_q <= flags_d;
            ff_q    <= ff_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        err_d   = err_q;
        flags_d = flags_q;
        ff_d    = ff_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_SETTLE;
                    vec_d   = 2'd0;
                    cnt_d   = C_SETTLE;
                    round_d = 8'd0;
                    err_d   = 8'd0;
                    flags_d = 4'd0;
                    ff_d    = 2'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_mismatch) begin
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    flags_d[vec_q] = 1'b1;
                    // err_q never returns to zero inside a campaign, so it marks the first miss
                    if (err_q == 8'd0) begin
                        ff_d = vec_q;
                    end
                end
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = C_SETTLE;
                    state_d = S_SETTLE;
                end else if (w_finish) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 8'd0);
                end else begin
                    round_d = round_q + 8'd1;
                    vec_d   = 2'd0;
                    cnt_d   = C_SETTLE;
                    state_d = S_SETTLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign a_o           = vec_q[1];
    assign b_o           = vec_q[0];
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign err_count_o   = err_q;
    assign fault_flags_o = flags_q;
    assign first_fail_o  = ff_q;

`ifdef HA_STUCK_DIAG_EN
    // seen: [0] sum=0, [1] sum=1, [2] carry=0, [3] carry=1
    logic [3:0] seen_q, seen_d;
    logic [3:0] stuck_q, stuck_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen_q  <= 4'd0;
            stuck_q <= 4'd0;
        end else begin
            seen_q  <= seen_d;
            stuck_q <= stuck_d;
        end
    end

    always_comb begin
        seen_d  = seen_q;
        stuck_d = stuck_q;
        if (w_accept) begin
            seen_d  = 4'd0;
            stuck_d = 4'd0;
        end else if (state_q == S_CHECK) begin
            seen_d[{1'b0, dut_sum_i}]   = 1'b1;
            seen_d[{1'b1, dut_carry_i}] = 1'b1;
            if (w_finish) begin
                stuck_d = {~seen_d[2], ~seen_d[3], ~seen_d[0], ~seen_d[1]};
            end
        end
    end

    assign sum_stuck0_o   = stuck_q[0];
    assign sum_stuck1_o   = stuck_q[1];
    assign carry_stuck0_o = stuck_q[2];
    assign carry_stuck1_o = stuck_q[3];
`else
    assign sum_stuck0_o   = 1'b0;
    assign sum_stuck1_o   = 1'b0;
    assign carry_stuck0_o = 1'b0;
    assign carry_stuck1_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ha_fault_monitor.sv
// Scoreboard bench: two monitor instances driven by table-defined (possibly faulty) half-adders.
`default_nettype none

module tb_ha_fault_monitor;

    localparam int S0 = 2;
    localparam int R0 = 1;
    localparam int S1 = 1;
    localparam int R1 = 100;

    typedef struct {
        int err;
        int flags;
        int ff;
        int pass;
        int stuck;      // {carry1, carry0, sum1, sum0}
        int start_cyc;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start0, start1;
    logic [3:0] fs0, fc0, fs1, fc1;   // bit v = DUT output when {a,b} == v
    logic sum0, carry0, sum1, carry1;
    logic [22:0] obs0, obs1;

    logic       a0, b0, busy0, done0, pass0, ss00, ss10, cs00, cs10;
    logic [7:0] err0;
    logic [3:0] fl0;
    logic [1:0] ff0;
    logic       a1, b1, busy1, done1, pass1, ss01, ss11, cs01, cs11;
    logic [7:0] err1;
    logic [3:0] fl1;
    logic [1:0] ff1;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    logic done0_prev = 1'b0;
    logic done1_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        sum0   = fs0[{a0, b0}];
        carry0 = fc0[{a0, b0}];
        sum1   = fs1[{a1, b1}];
        carry1 = fc1[{a1, b1}];
    end

    ha_fault_monitor #(.SETTLE(S0), .ROUNDS(R0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start0), .dut_sum_i(sum0), .dut_carry_i(carry0),
        .a_o(a0), .b_o(b0), .busy_o(busy0), .done_o(done0), .pass_o(pass0),
        .err_count_o(err0), .fault_flags_o(fl0), .first_fail_o(ff0),
        .sum_stuck0_o(ss00), .sum_stuck1_o(ss10), .carry_stuck0_o(cs00), .carry_stuck1_o(cs10)
    );

    ha_fault_monitor #(.SETTLE(S1), .ROUNDS(R1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .dut_sum_i(sum1), .dut_carry_i(carry1),
        .a_o(a1), .b_o(b1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
        .err_count_o(err1), .fault_flags_o(fl1), .first_fail_o(ff1),
        .sum_stuck0_o(ss01), .sum_stuck1_o(ss11), .carry_stuck0_o(cs01), .carry_stuck1_o(cs11)
    );

    assign obs0 = {a0, b0, busy0, done0, pass0, err0, fl0, ff0, cs10, cs00, ss10, ss00};
    assign obs1 = {a1, b1, busy1, done1, pass1, err1, fl1, ff1, cs11, cs01, ss11, ss01};

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: each round visits all four vectors in order, so results follow from the tables alone.
    function automatic exp_t model(input logic [3:0] fs, input logic [3:0] fc,
                                   input int rounds, input int settle, input int start_cyc);
        exp_t e;
        int   per = 0;
        int   total;
        bit   found = 0;
        bit   s0 = 0, s1 = 0, c0 = 0, c1 = 0;
        e.flags = 0;
        e.ff    = 0;
        for (int v = 0; v < 4; v++) begin
            int ea = (v >> 1) & 1;
            int eb = v & 1;
            if (int'(fs[v]) != (ea ^ eb) || int'(fc[v]) != (ea & eb)) begin
                per++;
                e.flags = e.flags | (1 << v);
                if (!found) begin
                    e.ff  = v;
                    found = 1;
                end
            end
            if (fs[v]) s1 = 1; else s0 = 1;
            if (fc[v]) c1 = 1; else c0 = 1;
        end
        total  = per * rounds;
        e.err  = (total > 255) ? 255 : total;
        e.pass = (total == 0) ? 1 : 0;
`ifdef HA_STUCK_DIAG_EN
        e.stuck = (int'(!c0) << 3) | (int'(!c1) << 2) | (int'(!s0) << 1) | int'(!s1);
`else
        e.stuck = 0;
`endif
        e.start_cyc = start_cyc;
        e.lat       = 4 * rounds * (settle + 1);
        return e;
    endfunction

    task automatic check_result(input int inst, input logic [22:0] o, input exp_t e, input int now);
        string p;
        p = (inst == 0) ? "i0" : "i1";
        chk({p, "_latency"}, now - e.start_cyc, e.lat);
        chk({p, "_err_count"}, int'(o[17:10]), e.err);
        chk({p, "_fault_flags"}, int'(o[9:6]), e.flags);
        chk({p, "_first_fail"}, int'(o[5:4]), e.ff);
        chk({p, "_pass"}, int'(o[18]), e.pass);
        chk({p, "_stuck"}, int'(o[3:0]), e.stuck);
        chk({p, "_ab_last"}, int'(o[22:21]), 3);
        chk({p, "_busy_at_done"}, int'(o[20]), 0);
    endtask

    always @(negedge clk) begin
        if (done0 && !done0_prev) begin
            if (q0.size() == 0) chk("i0_unexpected_done", 1, 0);
            else begin
                e0 = q0.pop_front();
                check_result(0, obs0, e0, cyc);
            end
        end
        done0_prev = done0;
    end

    always @(negedge clk) begin
        if (done1 && !done1_prev) begin
            if (q1.size() == 0) chk("i1_unexpected_done", 1, 0);
            else begin
                e1 = q1.pop_front();
                check_result(1, obs1, e1, cyc);
            end
        end
        done1_prev = done1;
    end

    task automatic run(input int inst, input logic [3:0] fs, input logic [3:0] fc, input bit mid_start);
        logic [22:0] o;
        int          left;
        @(negedge clk);
        if (inst == 0) begin fs0 = fs; fc0 = fc; start0 = 1'b1; end
        else           begin fs1 = fs; fc1 = fc; start1 = 1'b1; end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        o = (inst == 0) ? obs0 : obs1;
        chk("started_busy", int'(o[20]), 1);
        chk("started_cleared", int'({o[19:18], o[17:4]}), 0);
        if (inst == 0) q0.push_back(model(fs, fc, R0, S0, cyc));
        else           q1.push_back(model(fs, fc, R1, S1, cyc));
        if (mid_start && inst == 0) begin
            // lands on the CHECK cycle of vector 1
            repeat (5) @(negedge clk);
            start0 = 1'b1;
            @(negedge clk);
            start0 = 1'b0;
        end
        left = 3000;
        while (left > 0 && ((inst == 0) ? q0.size() : q1.size()) != 0) begin
            @(negedge clk);
            left--;
        end
        if (left == 0) begin
            chk("done_timeout", 0, 1);
            if (inst == 0) q0.delete(); else q1.delete();
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        fs0 = 4'b0110; fc0 = 4'b1000;
        fs1 = 4'b0110; fc1 = 4'b1000;
        repeat (3) @(negedge clk);
        chk("reset_obs0", int'(obs0), 0);
        chk("reset_obs1", int'(obs1), 0);
        rst_n = 1'b1;

        run(1, 4'b1001, 4'b0111, 0);                 // both outputs inverted: saturates
        run(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0);

        run(0, 4'b0110, 4'b1000, 0);                 // correct half-adder
        run(0, 4'b0000, 4'b1000, 0);                 // sum stuck-at-0
        run(0, 4'b0110, 4'b1111, 1);                 // carry stuck-at-1, start during CHECK
        for (int i = 0; i < 12; i++) begin
            run(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        // reset in the SETTLE phase of vector 2
        fs0 = 4'b0110; fc0 = 4'b1000;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_reset_vec2", int'({a0, b0, busy0}), 3'b101);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrun_reset_obs0", int'(obs0), 0);
        chk("midrun_reset_obs1", int'(obs1), 0);
        repeat (20) @(negedge clk);
        chk("idle_after_reset", int'({busy0, done0}), 0);

        // start coincident with reset is dropped
        rst_n = 1'b0; start0 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; start0 = 1'b0;
        @(negedge clk);
        chk("start_in_reset_ignored", int'(obs0), 0);

        run(0, 4'b0110, 4'b1000, 0);                 // clean campaign after reset
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
